// File: rtl/dma_pkg.sv
// dma_pkg: command and status bit positions, TRANSIZE limit and the channel
// state encoding shared by the DMA channel sequencer and its helpers.
package dma_pkg;

    localparam int CMD_ENABLE = 0;
    localparam int CMD_CLEAR  = 1;
    localparam int CMD_STOP   = 3;
    localparam int CMD_PAUSE  = 4;
    localparam int CMD_RESUME = 5;

    localparam int STAT_DONE    = 0;
    localparam int STAT_ERR     = 1;
    localparam int STAT_STOPPED = 2;
    localparam int STAT_ENABLED = 16;
    localparam int STAT_PAUSED  = 17;

    localparam logic [2:0] TRANSIZE_MAX = 3'd3;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_ACTIVE = 2'd1,
        CH_PAUSED = 2'd2
    } ch_state_e;

endpackage

// File: rtl/dma_addr_step.sv
// dma_addr_step: next beat address = addr + (inc << size), wrapping modulo 2^WIDTH.
module dma_addr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] addr,
    input  logic [15:0]      inc,
    input  logic [2:0]       size,
    output logic [WIDTH-1:0] addr_nxt
);

    assign addr_nxt = addr + (WIDTH'(inc) << size);

endmodule

// File: rtl/dma_chn_ctrl.sv
// dma_chn_ctrl: per-channel transfer sequencer. Decodes CH_CMD writes, issues
// one-beat copy requests, steps addresses/count, writes them back and keeps
// sticky done/err/stopped status with a masked interrupt.
// Optional feature: define DMA_CHN_PAUSE_EN to build PAUSE/RESUME and the PAUSED state.
module dma_chn_ctrl
    import dma_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               chn_cmd_wr_en_i,
    input  logic [WIDTH-1:0]   cfg_CH_CMD,
    input  logic [WIDTH-1:0]   cfg_CH_CTRL,
    input  logic [WIDTH-1:0]   cfg_CH_SRCADDR,
    input  logic [WIDTH-1:0]   cfg_CH_DESADDR,
    input  logic [WIDTH-1:0]   cfg_CH_XSIZE,
    input  logic [WIDTH-1:0]   cfg_CH_XADDRINC,
    input  logic [WIDTH-1:0]   cfg_CH_INTREN,
    output logic               xfer_req_o,
    output logic [WIDTH-1:0]   xfer_src_addr_o,
    output logic [WIDTH-1:0]   xfer_des_addr_o,
    output logic [2:0]         xfer_size_o,
    input  logic               xfer_ack_i,
    input  logic               xfer_err_i,
    output logic               updt_valid_o,
    output logic [3*WIDTH-1:0] src_des_xsize_updated_o,
    output logic [WIDTH-1:0]   ch_status_o,
    output logic               ch_irq_o
);

    ch_state_e              state;
    logic [WIDTH-1:0]       src_q, des_q;
    logic [WIDTH-1:0]       src_nxt, des_nxt;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [15:0]            src_inc_q, des_inc_q;
    logic [2:0]             size_q;
    logic                   req_q, updt_q;
    logic                   stop_pend, pause_pend;
    logic                   st_done, st_err, st_stop;

    logic cmd_stop, cmd_pause_bit, cmd_resume_bit;
    logic cmd_pause, cmd_resume, cmd_enable, cmd_clear;
    logic beat_ok, beat_err, last_beat, xsize_zero;
    logic set_done, set_err, set_stop, clr_status;
    logic unused_cfg;

    // Out-of-range TRANSIZE values are clamped to the widest supported beat.
    function automatic logic [2:0] sat_size(input logic [2:0] raw);
        return (raw > TRANSIZE_MAX) ? TRANSIZE_MAX : raw;
    endfunction

    // Command decode with STOP > PAUSE > RESUME > ENABLE priority; CLEAR stands alone.
    assign cmd_stop = chn_cmd_wr_en_i & cfg_CH_CMD[CMD_STOP];
`ifdef DMA_CHN_PAUSE_EN
    assign cmd_pause_bit  = chn_cmd_wr_en_i & cfg_CH_CMD[CMD_PAUSE];
    assign cmd_resume_bit = chn_cmd_wr_en_i & cfg_CH_CMD[CMD_RESUME];
    assign unused_cfg = ^{cfg_CH_CMD[WIDTH-1:6], cfg_CH_CMD[2], cfg_CH_CTRL[WIDTH-1:3],
                          cfg_CH_XSIZE[WIDTH-1:CNT_WIDTH], cfg_CH_INTREN[WIDTH-1:3]};
`else
    assign cmd_pause_bit  = 1'b0;
    assign cmd_resume_bit = 1'b0;
    assign unused_cfg = ^{cfg_CH_CMD[WIDTH-1:4], cfg_CH_CMD[2], cfg_CH_CTRL[WIDTH-1:3],
                          cfg_CH_XSIZE[WIDTH-1:CNT_WIDTH], cfg_CH_INTREN[WIDTH-1:3]};
`endif
    assign cmd_pause  = cmd_pause_bit & ~cmd_stop;
    assign cmd_resume = cmd_resume_bit & ~cmd_stop & ~cmd_pause_bit;
    assign cmd_enable = chn_cmd_wr_en_i & cfg_CH_CMD[CMD_ENABLE] & ~cmd_stop
                        & ~cmd_pause_bit & ~cmd_resume_bit;
    assign cmd_clear  = chn_cmd_wr_en_i & cfg_CH_CMD[CMD_CLEAR];

    assign beat_ok    = req_q & xfer_ack_i & ~xfer_err_i;
    assign beat_err   = req_q & xfer_ack_i & xfer_err_i;
    assign last_beat  = (cnt_q == CNT_WIDTH'(1));
    assign xsize_zero = (cfg_CH_XSIZE[CNT_WIDTH-1:0] == '0);

    dma_addr_step #(.WIDTH(WIDTH)) u_src_step (
        .addr(src_q), .inc(src_inc_q), .size(size_q), .addr_nxt(src_nxt)
    );
    dma_addr_step #(.WIDTH(WIDTH)) u_des_step (
        .addr(des_q), .inc(des_inc_q), .size(size_q), .addr_nxt(des_nxt)
    );

    // Status set events; a set in the same cycle as a clear takes precedence.
    always_comb begin
        set_done   = ((state == CH_IDLE) & cmd_enable & xsize_zero)
                   | ((state == CH_ACTIVE) & beat_ok & last_beat);
        set_err    = (state == CH_ACTIVE) & beat_err;
        set_stop   = ((state == CH_ACTIVE) & beat_ok & ~last_beat & (stop_pend | cmd_stop))
                   | ((state == CH_PAUSED) & cmd_stop);
        clr_status = cmd_clear | ((state == CH_IDLE) & cmd_enable);
    end

    // Channel FSM: request, address/count stepping and write-back strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= CH_IDLE;
            req_q      <= 1'b0;
            updt_q     <= 1'b0;
            stop_pend  <= 1'b0;
            pause_pend <= 1'b0;
            src_q      <= '0;
            des_q      <= '0;
            cnt_q      <= '0;
            src_inc_q  <= '0;
            des_inc_q  <= '0;
            size_q     <= '0;
        end else begin
            updt_q <= 1'b0;
            case (state)
                CH_IDLE: begin
                    stop_pend  <= 1'b0;
                    pause_pend <= 1'b0;
                    if (cmd_enable) begin
                        src_q     <= cfg_CH_SRCADDR;
                        des_q     <= cfg_CH_DESADDR;
                        cnt_q     <= cfg_CH_XSIZE[CNT_WIDTH-1:0];
                        src_inc_q <= cfg_CH_XADDRINC[15:0];
                        des_inc_q <= cfg_CH_XADDRINC[31:16];
                        size_q    <= sat_size(cfg_CH_CTRL[2:0]);
                        if (!xsize_zero) begin
                            state <= CH_ACTIVE;
                            req_q <= 1'b1;
                        end
                    end
                end
                CH_ACTIVE: begin
                    if (beat_err) begin
                        state      <= CH_IDLE;
                        req_q      <= 1'b0;
                        stop_pend  <= 1'b0;
                        pause_pend <= 1'b0;
                    end else if (beat_ok) begin
                        src_q  <= src_nxt;
                        des_q  <= des_nxt;
                        cnt_q  <= cnt_q - CNT_WIDTH'(1);
                        updt_q <= 1'b1;
                        if (last_beat || stop_pend || cmd_stop) begin
                            state      <= CH_IDLE;
                            req_q      <= 1'b0;
                            stop_pend  <= 1'b0;
                            pause_pend <= 1'b0;
                        end else if (pause_pend || cmd_pause) begin
                            state      <= CH_PAUSED;
                            req_q      <= 1'b0;
                            pause_pend <= 1'b0;
                        end
                    end else begin
                        if (cmd_stop)  stop_pend  <= 1'b1;
                        if (cmd_pause) pause_pend <= 1'b1;
                    end
                end
                CH_PAUSED: begin
                    if (cmd_stop) begin
                        state <= CH_IDLE;
                    end else if (cmd_resume) begin
                        state <= CH_ACTIVE;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= CH_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            st_stop <= 1'b0;
        end else begin
            st_done <= set_done | (st_done & ~clr_status);
            st_err  <= set_err  | (st_err  & ~clr_status);
            st_stop <= set_stop | (st_stop & ~clr_status);
        end
    end

    // Status word assembly.
    always_comb begin
        ch_status_o               = '0;
        ch_status_o[STAT_DONE]    = st_done;
        ch_status_o[STAT_ERR]     = st_err;
        ch_status_o[STAT_STOPPED] = st_stop;
        ch_status_o[STAT_ENABLED] = (state != CH_IDLE);
`ifdef DMA_CHN_PAUSE_EN
        ch_status_o[STAT_PAUSED]  = (state == CH_PAUSED);
`endif
    end

    assign xfer_req_o              = req_q;
    assign xfer_src_addr_o         = src_q;
    assign xfer_des_addr_o         = des_q;
    assign xfer_size_o             = size_q;
    assign updt_valid_o            = updt_q;
    assign src_des_xsize_updated_o = {{(WIDTH-CNT_WIDTH){1'b0}}, cnt_q, des_q, src_q};
    assign ch_irq_o                = |(ch_status_o[2:0] & cfg_CH_INTREN[2:0]);

endmodule

// File: tb/tb_dma_chn_ctrl.sv
// tb_dma_chn_ctrl: scoreboard bench for dma_chn_ctrl. A transfer-level model
// predicts every beat request and write-back; a monitor compares them as the
// DUT presents them. Directed scenarios plus a randomized batch.
`timescale 1ns/1ps
module tb_dma_chn_ctrl;

    localparam logic [31:0] C_EN     = 32'h01;
    localparam logic [31:0] C_CLR    = 32'h02;
    localparam logic [31:0] C_STOP   = 32'h08;
    localparam logic [31:0] C_PAUSE  = 32'h10;
    localparam logic [31:0] C_RESUME = 32'h20;

    logic        clk = 1'b0;
    logic        resetn;
    logic        chn_cmd_wr_en_i;
    logic [31:0] cfg_CH_CMD, cfg_CH_CTRL, cfg_CH_SRCADDR, cfg_CH_DESADDR;
    logic [31:0] cfg_CH_XSIZE, cfg_CH_XADDRINC, cfg_CH_INTREN;
    logic        xfer_req_o;
    logic [31:0] xfer_src_addr_o, xfer_des_addr_o;
    logic [2:0]  xfer_size_o;
    logic        xfer_ack_i, xfer_err_i;
    logic        updt_valid_o;
    logic [95:0] src_des_xsize_updated_o;
    logic [31:0] ch_status_o;
    logic        ch_irq_o;

    int errors = 0;
    int checks = 0;

    logic [66:0] exp_beat[$];
    logic [95:0] exp_wb[$];

    int ack_wait_fixed = 0;
    int ack_wait_max   = 0;
    int err_at         = -1;
    int beat_no        = 0;

    dma_chn_ctrl #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .chn_cmd_wr_en_i(chn_cmd_wr_en_i),
        .cfg_CH_CMD(cfg_CH_CMD), .cfg_CH_CTRL(cfg_CH_CTRL),
        .cfg_CH_SRCADDR(cfg_CH_SRCADDR), .cfg_CH_DESADDR(cfg_CH_DESADDR),
        .cfg_CH_XSIZE(cfg_CH_XSIZE), .cfg_CH_XADDRINC(cfg_CH_XADDRINC),
        .cfg_CH_INTREN(cfg_CH_INTREN),
        .xfer_req_o(xfer_req_o), .xfer_src_addr_o(xfer_src_addr_o),
        .xfer_des_addr_o(xfer_des_addr_o), .xfer_size_o(xfer_size_o),
        .xfer_ack_i(xfer_ack_i), .xfer_err_i(xfer_err_i),
        .updt_valid_o(updt_valid_o),
        .src_des_xsize_updated_o(src_des_xsize_updated_o),
        .ch_status_o(ch_status_o), .ch_irq_o(ch_irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfer-level model: beat i uses start + i*(inc<<ts); write-back carries
    // the address after the beat and the beats still remaining.
    function automatic void push_xfer(input logic [31:0] src, input logic [31:0] des,
                                      input int n, input logic [31:0] inc, input int ts,
                                      input int nb, input int err_idx);
        logic [31:0] sstep, dstep, s, d;
        sstep = {16'h0, inc[15:0]} << ts;
        dstep = {16'h0, inc[31:16]} << ts;
        for (int i = 0; i < nb; i++) begin
            s = src + sstep * 32'(i);
            d = des + dstep * 32'(i);
            exp_beat.push_back({3'(ts), s, d});
            if (i != err_idx)
                exp_wb.push_back({16'h0, 16'(n - i - 1), d + dstep, s + sstep});
        end
    endfunction

    // Monitor: compare each accepted beat and each write-back against the model.
    always @(negedge clk) begin
        if (resetn && xfer_req_o && xfer_ack_i) begin
            if (exp_beat.size() == 0) chk("beat_unexpected", {29'h0, xfer_size_o, xfer_src_addr_o, xfer_des_addr_o}, 96'h0);
            else chk("beat", {29'h0, xfer_size_o, xfer_src_addr_o, xfer_des_addr_o}, {29'h0, exp_beat.pop_front()});
        end
        if (resetn && updt_valid_o) begin
            if (exp_wb.size() == 0) chk("wb_unexpected", src_des_xsize_updated_o, 96'h0);
            else chk("writeback", src_des_xsize_updated_o, exp_wb.pop_front());
        end
    end

    // Datapath responder: acks a request after a fixed or random wait, erring on a chosen beat.
    initial begin
        int  wait_left;
        bit  have;
        xfer_ack_i = 1'b0;
        xfer_err_i = 1'b0;
        have = 1'b0;
        wait_left = 0;
        forever begin
            @(posedge clk); #1;
            xfer_ack_i = 1'b0;
            xfer_err_i = 1'b0;
            if (xfer_req_o) begin
                if (!have) begin
                    wait_left = (ack_wait_fixed >= 0) ? ack_wait_fixed : int'($urandom_range(ack_wait_max, 0));
                    have = 1'b1;
                end
                if (wait_left == 0) begin
                    xfer_ack_i = 1'b1;
                    xfer_err_i = (beat_no == err_at);
                    beat_no++;
                    have = 1'b0;
                end else begin
                    wait_left--;
                end
            end else begin
                have = 1'b0;
            end
        end
    end

    task automatic cmd(input logic [31:0] c);
        @(posedge clk); #1;
        chn_cmd_wr_en_i = 1'b1;
        cfg_CH_CMD      = c;
        @(posedge clk); #1;
        chn_cmd_wr_en_i = 1'b0;
        cfg_CH_CMD      = 32'h0;
    endtask

    task automatic setup(input logic [31:0] src, input logic [31:0] des, input int n,
                         input logic [31:0] inc, input int ts);
        cfg_CH_SRCADDR  = src;
        cfg_CH_DESADDR  = des;
        cfg_CH_XSIZE    = 32'(n);
        cfg_CH_XADDRINC = inc;
        cfg_CH_CTRL     = 32'(ts);
        beat_no         = 0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (ch_status_o[16] && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ch_status_o[16]) begin
            errors++;
            $display("FAIL %s_timeout: channel still enabled after %0d cycles, required idle", name, k);
        end
        repeat (2) @(negedge clk);
        chk({name, "_beats_left"}, 96'(exp_beat.size()), 96'h0);
        chk({name, "_wb_left"}, 96'(exp_wb.size()), 96'h0);
        exp_beat.delete();
        exp_wb.delete();
    endtask

    task automatic count_req(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (xfer_req_o) seen++;
        end
    endtask

    initial begin
        int seen, n, nb, e, ts, k;
        logic [31:0] s, d, inc;
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, n, nb, e, ts, k;
        logic [31:0] s, d, inc;
        resetn = 1'b0;
        chn_cmd_wr_en_i = 1'b0;
        cfg_CH_CMD = 0; cfg_CH_CTRL = 0; cfg_CH_SRCADDR = 0; cfg_CH_DESADDR = 0;
        cfg_CH_XSIZE = 0; cfg_CH_XADDRINC = 0; cfg_CH_INTREN = 32'h7;
        repeat (3) @(negedge clk);
        chk("rst_req", {95'h0, xfer_req_o}, 96'h0);
        chk("rst_updt", {95'h0, updt_valid_o}, 96'h0);
        chk("rst_status", {64'h0, ch_status_o}, 96'h0);
        chk("rst_irq", {95'h0, ch_irq_o}, 96'h0);
        chk("rst_addr", {32'h0, xfer_src_addr_o, xfer_des_addr_o}, 96'h0);
        chk("rst_wbbus", src_des_xsize_updated_o, 96'h0);
        @(posedge clk); #1 resetn = 1'b1;

        // Basic 4-beat copy, ack every cycle.
        cfg_CH_INTREN = 32'h1;
        ack_wait_fixed = 0; err_at = -1;
        setup(32'h1000, 32'h2000, 4, 32'h0001_0001, 2);
        push_xfer(32'h1000, 32'h2000, 4, 32'h0001_0001, 2, 4, -1);
        cmd(C_EN);
        wait_idle("t1");
        chk("t1_status", {64'h0, ch_status_o}, 96'h1);
        chk("t1_irq", {95'h0, ch_irq_o}, 96'h1);

        // Zero-length transfer.
        cmd(C_CLR);
        chk("t2_cleared", {64'h0, ch_status_o}, 96'h0);
        setup(32'h1000, 32'h2000, 0, 32'h0001_0001, 2);
        cmd(C_EN);
        @(negedge clk);
        chk("t2_done", {64'h0, ch_status_o}, 96'h1);
        count_req(5, seen);
        chk("t2_no_req", 96'(seen), 96'h0);

        // STOP while a request waits three cycles for ack.
        cfg_CH_INTREN = 32'h7;
        ack_wait_fixed = 3;
        setup(32'h3000, 32'h4000, 8, 32'h0001_0001, 1);
        push_xfer(32'h3000, 32'h4000, 8, 32'h0001_0001, 1, 1, -1);
        cmd(C_EN);
        cmd(C_STOP);
        @(negedge clk);
        chk("t3_req_held_a", {95'h0, xfer_req_o}, 96'h1);
        @(negedge clk);
        chk("t3_req_held_b", {95'h0, xfer_req_o}, 96'h1);
        wait_idle("t3");
        chk("t3_status", {64'h0, ch_status_o}, 96'h4);
        chk("t3_irq", {95'h0, ch_irq_o}, 96'h1);

        // Error on beat 2 of 5, then CLEAR.
        cfg_CH_INTREN = 32'h3;
        ack_wait_fixed = -1; ack_wait_max = 2; err_at = 1;
        setup(32'h5000, 32'h6000, 5, 32'h0002_0001, 0);
        push_xfer(32'h5000, 32'h6000, 5, 32'h0002_0001, 0, 2, 1);
        cmd(C_EN);
        wait_idle("t4");
        chk("t4_status", {64'h0, ch_status_o}, 96'h2);
        chk("t4_irq", {95'h0, ch_irq_o}, 96'h1);
        count_req(5, seen);
        chk("t4_no_req", 96'(seen), 96'h0);
        cmd(C_CLR);
        chk("t4_clr_status", {93'h0, ch_status_o[2:0]}, 96'h0);
        chk("t4_clr_irq", {95'h0, ch_irq_o}, 96'h0);

        // PAUSE during beat 1 of 3.
        cfg_CH_INTREN = 32'h1;
        ack_wait_fixed = 2; err_at = -1;
        setup(32'h7000, 32'h8000, 3, 32'h0001_0001, 3);
        push_xfer(32'h7000, 32'h8000, 3, 32'h0001_0001, 3, 3, -1);
        cmd(C_EN);
        cmd(C_PAUSE);
`ifdef DMA_CHN_PAUSE_EN
        k = 0;
        while (!ch_status_o[17] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_paused", {94'h0, ch_status_o[17:16]}, 96'h3);
        count_req(10, seen);
        chk("t5_no_req_paused", 96'(seen), 96'h0);
        cmd(C_RESUME);
`endif
        wait_idle("t5");
        chk("t5_status", {64'h0, ch_status_o}, 96'h1);

        // Source address wraps past 2^32.
        ack_wait_fixed = -1; ack_wait_max = 1;
        setup(32'hFFFF_FFFC, 32'h0000_0100, 2, 32'h0001_0001, 2);
        push_xfer(32'hFFFF_FFFC, 32'h0000_0100, 2, 32'h0001_0001, 2, 2, -1);
        cmd(C_EN);
        wait_idle("t6");
        chk("t6_status", {64'h0, ch_status_o}, 96'h1);

        // Asynchronous reset in the middle of a transfer.
        ack_wait_fixed = 6;
        setup(32'h9000, 32'hA000, 4, 32'h0001_0001, 0);
        cmd(C_EN);
        @(negedge clk);
        chk("t7_req_before", {95'h0, xfer_req_o}, 96'h1);
        #2 resetn = 1'b0;
        #1;
        chk("t7_req_async", {95'h0, xfer_req_o}, 96'h0);
        chk("t7_status", {64'h0, ch_status_o}, 96'h0);
        @(posedge clk); #1 resetn = 1'b1;

        // Randomized transfers.
        cfg_CH_INTREN = 32'h3;
        for (int r = 0; r < 10; r++) begin
            s   = $urandom;
            d   = $urandom;
            n   = int'($urandom_range(6, 1));
            inc = {16'($urandom_range(4, 0)), 16'($urandom_range(4, 0))};
            ts  = int'($urandom_range(3, 0));
            e   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
            nb  = (e >= 0) ? e + 1 : n;
            ack_wait_fixed = -1; ack_wait_max = 2; err_at = e;
            setup(s, d, n, inc, ts);
            push_xfer(s, d, n, inc, ts, nb, e);
            cmd(C_EN);
            wait_idle("rnd");
            chk("rnd_status", {64'h0, ch_status_o}, (e >= 0) ? 96'h2 : 96'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
